// File: rtl/cc_addr_mux_pipe.sv
// Register-address mux stage feeding the decoder: per-channel IR/MIR select, one output
// register, and a short line of in-flight destinations used to flag read-after-write hazards.
module cc_addr_mux_pipe #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_IR_SELECTION      = 5,
    parameter int CHANNELS                    = 3,
    parameter int WB_DEPTH                    = 2
) (
    input  logic                                            CC_ADDR_MUX_PIPE_CLOCK_50,
    input  logic                                            CC_ADDR_MUX_PIPE_RESET_InHigh,
    input  logic [CHANNELS*DATAWIDTH_DECODER_SELECTION-1:0] CC_ADDR_MUX_PIPE_MIR_FIELD,
    input  logic [CHANNELS*DATAWIDTH_IR_SELECTION-1:0]      CC_ADDR_MUX_PIPE_IR_FIELD,
    input  logic [CHANNELS-1:0]                             CC_ADDR_MUX_PIPE_SELECT,
    input  logic                                            CC_ADDR_MUX_PIPE_IN_VALID,
    input  logic                                            CC_ADDR_MUX_PIPE_STALL,
    output logic [CHANNELS*DATAWIDTH_DECODER_SELECTION-1:0] CC_ADDR_MUX_PIPE_TO_DECODER_OUT,
    output logic                                            CC_ADDR_MUX_PIPE_OUT_VALID,
    output logic [CHANNELS-2:0]                             CC_ADDR_MUX_PIPE_HAZARD
);

    localparam int DW = DATAWIDTH_DECODER_SELECTION;
    localparam int IW = DATAWIDTH_IR_SELECTION;
    localparam int NS = CHANNELS - 1;

    function automatic logic [DW-1:0] f_select(input logic sel, input logic [DW-1:0] mir,
                                               input logic [IW-1:0] ir);
        logic [DW-1:0] ext;
        ext = '0;
        ext[IW-1:0] = ir;
        return sel ? ext : mir;
    endfunction

    logic [CHANNELS*DW-1:0]         w_sel_p0;
    logic [CHANNELS*DW-1:0]         r_addr_p1;
    logic                           r_vld_p1;
    logic [WB_DEPTH-1:0]            r_pend_vld_p2;
    logic [WB_DEPTH-1:0][DW-1:0]    r_pend_addr_p2;
    logic [DW-1:0]                  w_dest_p1;
    logic [NS-1:0]                  w_hazard_p1;
    logic                           w_advance;

    // Stage 0: per-channel address selection
    always_comb begin
        w_sel_p0 = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_sel_p0[k*DW +: DW] = f_select(CC_ADDR_MUX_PIPE_SELECT[k],
                                            CC_ADDR_MUX_PIPE_MIR_FIELD[k*DW +: DW],
                                            CC_ADDR_MUX_PIPE_IR_FIELD[k*IW +: IW]);
        end
    end

    assign w_advance = ~CC_ADDR_MUX_PIPE_STALL;
    assign w_dest_p1 = r_addr_p1[NS*DW +: DW];

    // Stage 1: output register; stage 2: destinations that have already left the output
    always_ff @(posedge CC_ADDR_MUX_PIPE_CLOCK_50) begin
        if (CC_ADDR_MUX_PIPE_RESET_InHigh) begin
            r_addr_p1      <= '0;
            r_vld_p1       <= 1'b0;
            r_pend_vld_p2  <= '0;
            r_pend_addr_p2 <= '0;
        end else if (w_advance) begin
            if (CC_ADDR_MUX_PIPE_IN_VALID) begin
                r_addr_p1 <= w_sel_p0;
            end
            r_vld_p1 <= CC_ADDR_MUX_PIPE_IN_VALID;
            for (int j = WB_DEPTH - 1; j > 0; j--) begin
                r_pend_vld_p2[j]  <= r_pend_vld_p2[j-1];
                r_pend_addr_p2[j] <= r_pend_addr_p2[j-1];
            end
            // Register 0 is hardwired, so writing it never creates a dependency
            r_pend_vld_p2[0]  <= r_vld_p1 && (w_dest_p1 != '0);
            r_pend_addr_p2[0] <= w_dest_p1;
        end
    end

    // The output's own destination is not in the pending line yet, so it cannot self-match
    always_comb begin
        w_hazard_p1 = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < WB_DEPTH; j++) begin
                if (r_vld_p1 && (r_addr_p1[i*DW +: DW] != '0) && r_pend_vld_p2[j] &&
                    (r_pend_addr_p2[j] == r_addr_p1[i*DW +: DW])) begin
                    w_hazard_p1[i] = 1'b1;
                end
            end
        end
    end

    assign CC_ADDR_MUX_PIPE_TO_DECODER_OUT = r_addr_p1;
    assign CC_ADDR_MUX_PIPE_OUT_VALID      = r_vld_p1;
    assign CC_ADDR_MUX_PIPE_HAZARD         = w_hazard_p1;

endmodule

// File: tb/tb_cc_addr_mux_pipe.sv
// Directed bench for cc_addr_mux_pipe at default parameters: select table plus
// hand-written hazard, stall and reset sequences.
module tb_cc_addr_mux_pipe;

    logic        clk;
    logic        rst;
    logic [17:0] mir;
    logic [14:0] ir;
    logic [2:0]  sel;
    logic        in_vld;
    logic        stall;
    logic [17:0] dout;
    logic        out_vld;
    logic [1:0]  hazard;

    int checks   = 0;
    int failures = 0;

    cc_addr_mux_pipe dut (
        .CC_ADDR_MUX_PIPE_CLOCK_50       (clk),
        .CC_ADDR_MUX_PIPE_RESET_InHigh   (rst),
        .CC_ADDR_MUX_PIPE_MIR_FIELD      (mir),
        .CC_ADDR_MUX_PIPE_IR_FIELD       (ir),
        .CC_ADDR_MUX_PIPE_SELECT         (sel),
        .CC_ADDR_MUX_PIPE_IN_VALID       (in_vld),
        .CC_ADDR_MUX_PIPE_STALL          (stall),
        .CC_ADDR_MUX_PIPE_TO_DECODER_OUT (dout),
        .CC_ADDR_MUX_PIPE_OUT_VALID      (out_vld),
        .CC_ADDR_MUX_PIPE_HAZARD         (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  sel;
        logic [17:0] mir;
        logic [14:0] ir;
        logic [17:0] exp_out;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b,
                         input logic [5:0] c);
        in_vld = v;
        sel    = 3'b000;
        mir    = {c, b, a};
        ir     = 15'h7fff;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; drive(1'b0, 6'd0, 6'd0, 6'd0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'b001, {6'd3, 6'd2, 6'b100101},  {5'd9, 5'd8, 5'b10011},   {6'd3, 6'd2, 6'b010011}};
        vecs[1] = '{3'b000, {6'd3, 6'd2, 6'b100101},  {5'd9, 5'd8, 5'b10011},   {6'd3, 6'd2, 6'b100101}};
        vecs[2] = '{3'b111, {6'd63, 6'd63, 6'd63},    {5'd31, 5'd1, 5'd0},      {6'd31, 6'd1, 6'd0}};
        vecs[3] = '{3'b010, {6'd40, 6'd50, 6'd60},    {5'd7, 5'd17, 5'd27},     {6'd40, 6'd17, 6'd60}};
        vecs[4] = '{3'b100, {6'd63, 6'd63, 6'd63},    {5'd16, 5'd0, 5'd0},      {6'd16, 6'd63, 6'd63}};
        vecs[5] = '{3'b000, {6'd0, 6'd0, 6'd0},       {5'd31, 5'd31, 5'd31},    {6'd0, 6'd0, 6'd0}};

        // reset overrides stall and valid input
        rst = 1'b1; stall = 1'b1; in_vld = 1'b1; sel = 3'b111; mir = '1; ir = '1;
        cyc(); cyc();
        rst = 1'b0; stall = 1'b0;
        chk("reset_out", 32'(dout), 32'd0);
        chk("reset_vld", 32'(out_vld), 32'd0);
        chk("reset_haz", 32'(hazard), 32'd0);

        for (int n = 0; n < 6; n++) begin
            in_vld = 1'b1; sel = vecs[n].sel; mir = vecs[n].mir; ir = vecs[n].ir;
            cyc();
            chk($sformatf("vec%0d_out", n), 32'(dout), 32'(vecs[n].exp_out));
            chk($sformatf("vec%0d_vld", n), 32'(out_vld), 32'd1);
        end

        // dest 5, bubble, source A=5: hazard while the reader is on the output
        do_reset();
        drive(1'b1, 6'd2, 6'd1, 6'd5); cyc();
        chk("raw1_first_haz", 32'(hazard), 32'd0);
        drive(1'b0, 6'd33, 6'd34, 6'd35); cyc();
        chk("raw1_bubble_vld", 32'(out_vld), 32'd0);
        chk("raw1_bubble_hold", 32'(dout), 32'({6'd5, 6'd1, 6'd2}));
        chk("raw1_bubble_haz", 32'(hazard), 32'd0);
        drive(1'b1, 6'd5, 6'd3, 6'd4); cyc();
        chk("raw1_vld", 32'(out_vld), 32'd1);
        chk("raw1_haz", 32'(hazard), 32'b01);

        // two bubbles push the writer past the pending line
        do_reset();
        drive(1'b1, 6'd2, 6'd1, 6'd5); cyc();
        drive(1'b0, 6'd5, 6'd5, 6'd5); cyc();
        drive(1'b0, 6'd5, 6'd5, 6'd5); cyc();
        drive(1'b1, 6'd5, 6'd3, 6'd4); cyc();
        chk("raw_expired_haz", 32'(hazard), 32'd0);

        // back-to-back: source B of the follower matches
        do_reset();
        drive(1'b1, 6'd1, 6'd2, 6'd5); cyc();
        drive(1'b1, 6'd3, 6'd5, 6'd6); cyc();
        chk("raw_b_haz", 32'(hazard), 32'b10);

        // register 0 never hazards
        do_reset();
        drive(1'b1, 6'd1, 6'd2, 6'd0); cyc();
        drive(1'b1, 6'd0, 6'd0, 6'd8); cyc();
        chk("zero_reg_haz", 32'(hazard), 32'd0);

        // an instruction's own destination does not flag its sources
        do_reset();
        drive(1'b1, 6'd9, 6'd9, 6'd9); cyc();
        chk("self_dest_haz", 32'(hazard), 32'd0);

        // stall freezes output, valid, hazard and pending line
        do_reset();
        drive(1'b1, 6'd11, 6'd12, 6'd13); cyc();
        drive(1'b1, 6'd13, 6'd1, 6'd2); cyc();
        chk("pre_stall_haz", 32'(hazard), 32'b01);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            drive(s[0], 6'(40 + s), 6'(50 + s), 6'(60 + s));
            cyc();
            chk($sformatf("stall%0d_out", s), 32'(dout), 32'({6'd2, 6'd1, 6'd13}));
            chk($sformatf("stall%0d_vld", s), 32'(out_vld), 32'd1);
            chk($sformatf("stall%0d_haz", s), 32'(hazard), 32'b01);
        end
        stall = 1'b0;
        drive(1'b1, 6'd21, 6'd22, 6'd23); cyc();
        chk("post_stall_out", 32'(dout), 32'({6'd23, 6'd22, 6'd21}));
        chk("post_stall_vld", 32'(out_vld), 32'd1);
        chk("post_stall_haz", 32'(hazard), 32'd0);
        drive(1'b1, 6'd2, 6'd13, 6'd0); cyc();
        chk("post_stall_pend", 32'(hazard), 32'b01);

        // reset mid-stream discards in-flight destinations
        do_reset();
        drive(1'b1, 6'd1, 6'd2, 6'd7); cyc();
        drive(1'b1, 6'd3, 6'd4, 6'd6); cyc();
        rst = 1'b1; stall = 1'b1; drive(1'b1, 6'd7, 6'd7, 6'd7); cyc();
        chk("midrst_out", 32'(dout), 32'd0);
        chk("midrst_vld", 32'(out_vld), 32'd0);
        chk("midrst_haz", 32'(hazard), 32'd0);
        rst = 1'b0; stall = 1'b0;
        drive(1'b1, 6'd7, 6'd6, 6'd10); cyc();
        chk("postrst_vld", 32'(out_vld), 32'd1);
        chk("postrst_haz", 32'(hazard), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_addr_mux_pipe.md
CC_ADDR_MUX_PIPE -- requirements
Module: cc_addr_mux_pipe

Interface
REQ-001 SHALL have parameter DATAWIDTH_DECODER_SELECTION, default 6, giving the register-address width presented to the decoder.
REQ-002 SHALL have parameter DATAWIDTH_IR_SELECTION, default 5, giving the IR register-field width; DATAWIDTH_IR_SELECTION <= DATAWIDTH_DECODER_SELECTION.
REQ-003 SHALL have parameter CHANNELS, default 3, giving the number of address channels (minimum 2); channels 0..CHANNELS-2 are sources (A, B, ...); channel CHANNELS-1 is the destination (C).
REQ-004 SHALL have parameter WB_DEPTH, default 2, giving the number of in-flight destination addresses tracked (minimum 1).
REQ-005 CC_ADDR_MUX_PIPE_CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-006 CC_ADDR_MUX_PIPE_RESET_InHigh  input  1  reset, synchronous, active-high.
REQ-007 CC_ADDR_MUX_PIPE_MIR_FIELD  input  CHANNELS*DATAWIDTH_DECODER_SELECTION  packed microinstruction address fields; channel k in slice k.
REQ-008 CC_ADDR_MUX_PIPE_IR_FIELD  input  CHANNELS*DATAWIDTH_IR_SELECTION  packed instruction-register address fields; channel k in slice k.
REQ-009 CC_ADDR_MUX_PIPE_SELECT  input  CHANNELS  per-channel select; 1 = IR field, 0 = MIR field.
REQ-010 CC_ADDR_MUX_PIPE_IN_VALID  input  1  inputs carry a valid microinstruction this cycle.
REQ-011 CC_ADDR_MUX_PIPE_STALL  input  1  freeze all state this cycle.
REQ-012 CC_ADDR_MUX_PIPE_TO_DECODER_OUT  output  CHANNELS*DATAWIDTH_DECODER_SELECTION  registered selected addresses, packed as the inputs.
REQ-013 CC_ADDR_MUX_PIPE_OUT_VALID  output  1  registered; TO_DECODER_OUT holds a valid microinstruction.
REQ-014 CC_ADDR_MUX_PIPE_HAZARD  output  CHANNELS-1  per-source flag: source address matches an in-flight destination.

Function
REQ-015 Selection per channel SHALL be: SELECT[k]=1 -> IR slice zero-extended (upper DATAWIDTH_DECODER_SELECTION-DATAWIDTH_IR_SELECTION bits 0); SELECT[k]=0 -> MIR slice unchanged.
REQ-016 Advance cycle = STALL=0 and reset=0.
REQ-017 On an advance cycle with IN_VALID=1, TO_DECODER_OUT SHALL load the selected addresses and OUT_VALID SHALL go 1; latency exactly 1 clock.
REQ-018 On an advance cycle with IN_VALID=0, OUT_VALID SHALL go 0 (bubble) and TO_DECODER_OUT SHALL hold its previous value.
REQ-019 When STALL=1, TO_DECODER_OUT, OUT_VALID and the pending line SHALL hold; inputs ignored.
REQ-020 Pending line: WB_DEPTH entries {valid, address}; on every advance cycle entry 0 SHALL load {OUT_VALID and dest!=0, dest channel of TO_DECODER_OUT}, entry j SHALL load entry j-1, entry WB_DEPTH-1 discarded; bubbles occupy slots.
REQ-021 HAZARD[i] SHALL be combinational from registers: OUT_VALID=1 and source i of TO_DECODER_OUT != 0 and equal to the address of any valid pending entry; else 0.
REQ-022 Address 0 (hardwired-zero register) SHALL never produce a hazard and SHALL never enter the pending line as valid.
REQ-023 The current output's own destination SHALL NOT cause a hazard on its own sources.

Reset
REQ-024 Reset SHALL override STALL and IN_VALID: next edge TO_DECODER_OUT=0, OUT_VALID=0, all pending entries invalid and address 0, hence HAZARD=0.
REQ-025 Reset mid-stream SHALL discard all in-flight destinations; no post-reset hazard against pre-reset addresses.

Verification (CHANNELS=3, DECODER=6, IR=5, WB_DEPTH=2)
REQ-026 ch0 SELECT=1, IR=5'b10011 -> ch0 out 6'b010011 next cycle; ch0 SELECT=0, MIR=6'b100101 -> 6'b100101; OUT_VALID=1 both.
REQ-027 Instr1 dest=5, bubble, instr3 src A=5 -> HAZARD[0]=1 while instr3 on output; instr1 dest=5, bubble, bubble, instr4 A=5 -> HAZARD[0]=0.
REQ-028 Instr1 dest=5, instr2 src B=5 -> HAZARD[1]=1, HAZARD[0]=0; dest=0 followed by src A=0 -> HAZARD=0.
REQ-029 STALL=1 for 3 cycles with changing inputs -> outputs, OUT_VALID, HAZARD unchanged; first advance cycle after loads current inputs.
REQ-030 Instr dest=7 in flight, reset with STALL=1 -> all outputs 0; then instr src A=7 -> HAZARD[0]=0.
